// File: rtl/word_pair_packer.sv
// word_pair_packer
//   Receives a stream of single DATA_W words and packs consecutive pairs into
//   one 2*DATA_W beat laid out as {hi,lo}, where lo is the earlier word.
//   A frame with an odd word count ends in a half beat: mask 01 and the hi
//   half is zero-filled.
//   The output stage holds one beat. While it is occupied, a new word is
//   accepted only in a cycle where that beat retires, so a word never
//   overwrites a beat that has not been taken.
//   phase and finish report the packing phase and the end-of-frame handoff
//   to the controlling FSM.

module word_pair_packer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [2*DATA_W-1:0]   out_data,
  output logic [1:0]            out_mask,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  phase,
  output logic [CNT_W-1:0]      pair_count,
  output logic                  finish
);

  // LO: waiting for the first word of a pair.
  // HI: lo word held, waiting for its partner.
  // FULL: a packed beat is presented downstream.
  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    ST_HI   = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [DATA_W-1:0]     r_lo;
  logic [DATA_W-1:0]     w_lo_nxt;
  logic                  r_out_valid;
  logic                  w_out_valid_nxt;
  logic [2*DATA_W-1:0]   r_out_data;
  logic [2*DATA_W-1:0]   w_out_data_nxt;
  logic [1:0]            r_out_mask;
  logic [1:0]            w_out_mask_nxt;
  logic                  r_out_last;
  logic                  w_out_last_nxt;
  logic                  r_phase;
  logic                  w_phase_nxt;
  logic [CNT_W-1:0]      r_pair_count;
  logic [CNT_W-1:0]      w_pair_count_nxt;
  logic                  r_finish;
  logic                  w_finish_nxt;

  logic                  w_in_ready;
  logic                  w_in_acc;
  logic                  w_out_acc;
  logic                  w_lo_slot;

  // Handshake decode: in FULL the input is only open when the beat retires.
  always_comb begin
    w_in_ready = 1'b1;
    if (r_state == ST_FULL) begin
      w_in_ready = out_ready;
    end else begin
      w_in_ready = 1'b1;
    end
    w_in_acc  = in_valid & w_in_ready;
    w_out_acc = r_out_valid & out_ready;
    // A word taken in LO, or in FULL while the beat retires, is a lo word.
    w_lo_slot = (r_state == ST_LO) | ((r_state == ST_FULL) & out_ready);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_LO;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LO: begin
        if (w_in_acc) begin
          w_state_nxt = in_last ? ST_FULL : ST_HI;
        end else begin
          w_state_nxt = ST_LO;
        end
      end
      ST_HI: begin
        if (w_in_acc) begin
          w_state_nxt = ST_FULL;
        end else begin
          w_state_nxt = ST_HI;
        end
      end
      ST_FULL: begin
        if (!out_ready) begin
          w_state_nxt = ST_FULL;
        end else if (w_in_acc) begin
          w_state_nxt = in_last ? ST_FULL : ST_HI;
        end else begin
          w_state_nxt = ST_LO;
        end
      end
      default: begin
        w_state_nxt = ST_LO;
      end
    endcase
  end

  // Output next-values: beat loading, lo capture, frame counter, finish.
  always_comb begin
    w_lo_nxt         = r_lo;
    w_out_data_nxt   = r_out_data;
    w_out_mask_nxt   = r_out_mask;
    w_out_last_nxt   = r_out_last;
    w_pair_count_nxt = r_pair_count;
    w_finish_nxt     = 1'b0;
    w_out_valid_nxt  = (w_state_nxt == ST_FULL);
    w_phase_nxt      = (w_state_nxt == ST_HI);

    if (w_in_acc && w_lo_slot) begin
      if (in_last) begin
        // Lone last word: half beat, hi half zero-filled.
        w_out_data_nxt = {{DATA_W{1'b0}}, in_data};
        w_out_mask_nxt = 2'b01;
        w_out_last_nxt = 1'b1;
      end else begin
        w_lo_nxt = in_data;
      end
    end else if (w_in_acc && (r_state == ST_HI)) begin
      w_out_data_nxt = {in_data, r_lo};
      w_out_mask_nxt = 2'b11;
      w_out_last_nxt = in_last;
    end else begin
      w_lo_nxt = r_lo;
    end

    if (w_out_acc) begin
      if (r_out_last) begin
        w_pair_count_nxt = {CNT_W{1'b0}};
        w_finish_nxt     = 1'b1;
      end else begin
        w_pair_count_nxt = r_pair_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      w_pair_count_nxt = r_pair_count;
    end
  end

  // Output and holding registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lo         <= {DATA_W{1'b0}};
      r_out_valid  <= 1'b0;
      r_out_data   <= {(2*DATA_W){1'b0}};
      r_out_mask   <= 2'b00;
      r_out_last   <= 1'b0;
      r_phase      <= 1'b0;
      r_pair_count <= {CNT_W{1'b0}};
      r_finish     <= 1'b0;
    end else begin
      r_lo         <= w_lo_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_data   <= w_out_data_nxt;
      r_out_mask   <= w_out_mask_nxt;
      r_out_last   <= w_out_last_nxt;
      r_phase      <= w_phase_nxt;
      r_pair_count <= w_pair_count_nxt;
      r_finish     <= w_finish_nxt;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_mask   = r_out_mask;
  assign out_last   = r_out_last;
  assign phase      = r_phase;
  assign pair_count = r_pair_count;
  assign finish     = r_finish;

endmodule

// File: tb/tb_word_pair_packer.sv
// Self-checking bench for word_pair_packer. Two instances share stimulus:
// one with default widths and one with CNT_W=2 to exercise counter wrap.
// Expected beats come from a word-level pairing model pushed to a queue.

module tb_word_pair_packer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready,  in_ready2;
  logic        out_valid, out_valid2;
  logic [15:0] out_data,  out_data2;
  logic [1:0]  out_mask,  out_mask2;
  logic        out_last,  out_last2;
  logic        phase,     phase2;
  logic [15:0] pair_count;
  logic [1:0]  pair_count2;
  logic        finish,    finish2;

  word_pair_packer #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_mask(out_mask), .out_last(out_last),
    .out_ready(out_ready), .phase(phase), .pair_count(pair_count), .finish(finish)
  );

  word_pair_packer #(.DATA_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_mask(out_mask2), .out_last(out_last2),
    .out_ready(out_ready), .phase(phase2), .pair_count(pair_count2), .finish(finish2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  m;
    logic        l;
  } beat_t;

  beat_t       sb[$];
  logic        have_lo;
  logic [7:0]  lo_word;
  logic [15:0] exp_cnt;
  logic [1:0]  exp_cnt2;
  logic        exp_fin;
  int          n_cmp;
  int          n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    have_lo  = 1'b0;
    lo_word  = 8'h00;
    exp_cnt  = 16'd0;
    exp_cnt2 = 2'd0;
    exp_fin  = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_mask", {30'd0, out_mask}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_phase", {31'd0, phase}, 32'd0);
    chk("rst_pair_count", {16'd0, pair_count}, 32'd0);
    chk("rst_finish", {31'd0, finish}, 32'd0);
    chk("rst_out_valid_w2", {31'd0, out_valid2}, 32'd0);
    chk("rst_phase_w2", {31'd0, phase2}, 32'd0);
    chk("rst_pair_count_w2", {30'd0, pair_count2}, 32'd0);
  endtask

  // Compare every observable against the model, then advance the model by
  // the transfers that happen at the coming rising edge.
  task automatic check_cycle(output logic acc);
    logic  exp_rdy;
    logic  exp_vld;
    beat_t b;
    exp_vld = (sb.size() != 0);
    exp_rdy = !exp_vld || out_ready;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("in_ready_w2", {31'd0, in_ready2}, {31'd0, exp_rdy});
    chk("phase", {31'd0, phase}, {31'd0, have_lo});
    chk("phase_w2", {31'd0, phase2}, {31'd0, have_lo});
    chk("pair_count", {16'd0, pair_count}, {16'd0, exp_cnt});
    chk("pair_count_w2", {30'd0, pair_count2}, {30'd0, exp_cnt2});
    chk("finish", {31'd0, finish}, {31'd0, exp_fin});
    chk("finish_w2", {31'd0, finish2}, {31'd0, exp_fin});
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_vld});
    chk("out_valid_w2", {31'd0, out_valid2}, {31'd0, exp_vld});
    exp_fin = 1'b0;
    if (exp_vld) begin
      b = sb[0];
      chk("out_data", {16'd0, out_data}, {16'd0, b.d});
      chk("out_mask", {30'd0, out_mask}, {30'd0, b.m});
      chk("out_last", {31'd0, out_last}, {31'd0, b.l});
      chk("out_data_w2", {16'd0, out_data2}, {16'd0, b.d});
      chk("out_mask_w2", {30'd0, out_mask2}, {30'd0, b.m});
      if (out_ready) begin
        void'(sb.pop_front());
        if (b.l) begin
          exp_cnt  = 16'd0;
          exp_cnt2 = 2'd0;
          exp_fin  = 1'b1;
        end else begin
          exp_cnt  = exp_cnt + 16'd1;
          exp_cnt2 = exp_cnt2 + 2'd1;
        end
      end
    end
    acc = in_valid && exp_rdy;
    if (acc) begin
      if (have_lo) begin
        sb.push_back('{d: {in_data, lo_word}, m: 2'b11, l: in_last});
        have_lo = 1'b0;
      end else if (in_last) begin
        sb.push_back('{d: {8'h00, in_data}, m: 2'b01, l: 1'b1});
      end else begin
        have_lo = 1'b1;
        lo_word = in_data;
      end
    end
  endtask

  // One clock: drive at posedge+1, check at negedge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic l,
                     input logic ordy, output logic acc);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    @(negedge clk);
    check_cycle(acc);
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      cyc(1'b1, d, l, 1'b1, acc);
      n++;
    end
    if (!acc) chk("push_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, acc);
  endtask

  initial begin
    logic acc;
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #1;
    chk_reset_vals();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Two full pairs, frame ends on a full beat.
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    push(8'h44, 1'b1);
    idle(3);

    // Odd frame: trailing half beat.
    push(8'hA1, 1'b0);
    push(8'hA2, 1'b0);
    push(8'hA3, 1'b1);
    idle(3);

    // Backpressure: beat pending, out_ready low for 5 cycles.
    cyc(1'b1, 8'hB1, 1'b0, 1'b0, acc);
    cyc(1'b1, 8'hB2, 1'b0, 1'b0, acc);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'hB3, 1'b0, 1'b0, acc);
      chk("stall_no_consume", {31'd0, acc}, 32'd0);
    end
    push(8'hB3, 1'b0);
    push(8'hB4, 1'b1);
    idle(3);

    // Continuous streaming: 8 words back to back.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'hC0 + 8'(i), (i == 7) ? 1'b1 : 1'b0, 1'b1, acc);
      chk("stream_accept", {31'd0, acc}, 32'd1);
    end
    idle(3);

    // Reset with a lo word held.
    push(8'h55, 1'b0);
    reset = 1'b1;
    model_reset();
    #1;
    chk_reset_vals();
    @(posedge clk);
    #1;
    reset = 1'b0;
    push(8'h66, 1'b0);
    push(8'h77, 1'b1);
    idle(3);

    // Counter wrap on the CNT_W=2 instance: 5 non-last pairs, then a last pair.
    for (int i = 0; i < 5; i++) begin
      push(8'hD0 + 8'(2*i), 1'b0);
      push(8'hD1 + 8'(2*i), 1'b0);
    end
    push(8'hE0, 1'b0);
    push(8'hE1, 1'b1);
    idle(3);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
